// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and opcode decode helpers
// for the ALU operation sequencer.
package alu_seq_pkg;

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_MFHI     = 3'd3,
    ST_MFLO     = 3'd4,
    ST_RESP0    = 3'd5,
    ST_RESP1    = 3'd6
  } seq_state_e;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_MULTU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Subtract and set-less-than both need the ALU to invert operand B.
  function automatic logic op_binvert(input logic [5:0] op);
    logic inv;
    case (op)
      OP_SUB, OP_SLT: inv = 1'b1;
      default:        inv = 1'b0;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time onto an external combinational ALU and
// returns the result as one beat (or Hi then Lo beats for MULTU).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic        alu_binvert,
  input  logic [31:0] alu_output,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_hi,
  output logic        rsp_last,
  output logic        rsp_err
);

  // Counter reloads with MUL_CYCLES-1 so MUL_WAIT lasts exactly MUL_CYCLES cycles.
  localparam logic [5:0] CNT_LOAD = 6'(MUL_CYCLES - 1);

  seq_state_e  state_r, state_s;
  logic [5:0]  op_r, op_s;
  logic [31:0] a_r, a_s;
  logic [31:0] b_r, b_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;
  logic        err_r, err_s;
  logic [5:0]  cnt_r, cnt_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      op_r    <= 6'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      err_r   <= 1'b0;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    err_s   = err_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          op_s  = req_op;
          a_s   = req_a;
          b_s   = req_b;
          hi_s  = 32'd0;
          lo_s  = 32'd0;
          cnt_s = 6'd0;
          if (op_supported(req_op)) begin
            err_s   = 1'b0;
            state_s = ST_ISSUE;
          end else begin
            err_s   = 1'b1;
            state_s = ST_RESP1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (op_r == OP_MULTU) begin
          cnt_s   = CNT_LOAD;
          state_s = ST_MUL_WAIT;
        end else begin
          lo_s    = alu_output;
          state_s = ST_RESP1;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_r == 6'd0) begin
          state_s = ST_MFHI;
        end else begin
          cnt_s = cnt_r - 6'd1;
        end
      end
      ST_MFHI: begin
        hi_s    = alu_output;
        state_s = ST_MFLO;
      end
      ST_MFLO: begin
        lo_s    = alu_output;
        state_s = ST_RESP0;
      end
      ST_RESP0: begin
        if (rsp_ready) begin
          state_s = ST_RESP1;
        end else begin
          state_s = ST_RESP0;
        end
      end
      ST_RESP1: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode; every output is a function of registered state only.
  always_comb begin
    req_ready   = 1'b0;
    alu_signal  = 6'd0;
    alu_dataA   = 32'd0;
    alu_dataB   = 32'd0;
    alu_binvert = op_binvert(op_r);
    rsp_valid   = 1'b0;
    rsp_data    = 32'd0;
    rsp_hi      = 1'b0;
    rsp_last    = 1'b0;
    rsp_err     = 1'b0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_ISSUE: begin
        alu_signal = op_r;
        alu_dataA  = a_r;
        alu_dataB  = b_r;
      end
      ST_MUL_WAIT: begin
        alu_signal = OP_MULTU;
        alu_dataA  = a_r;
        alu_dataB  = b_r;
      end
      ST_MFHI: begin
        alu_signal = OP_MFHI;
        alu_dataA  = a_r;
        alu_dataB  = b_r;
      end
      ST_MFLO: begin
        alu_signal = OP_MFLO;
        alu_dataA  = a_r;
        alu_dataB  = b_r;
      end
      ST_RESP0: begin
        rsp_valid = 1'b1;
        rsp_data  = hi_r;
        rsp_hi    = 1'b1;
      end
      ST_RESP1: begin
        rsp_valid = 1'b1;
        rsp_data  = lo_r;
        rsp_last  = 1'b1;
        rsp_err   = err_r;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural
// MIPS-style ALU model (Hi/Lo latched while MULTU is presented).
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = 6'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [5:0]  alu_signal;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic        alu_binvert;
  logic [31:0] alu_output;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_hi;
  logic        rsp_last;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  logic [5:0]  sig_log [0:255];
  logic        binv_log [0:255];

  always #5 clk = ~clk;

  alu_op_sequencer #(.MUL_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_signal(alu_signal), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
    .alu_binvert(alu_binvert), .alu_output(alu_output),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_hi(rsp_hi), .rsp_last(rsp_last), .rsp_err(rsp_err)
  );

  always @(posedge clk) begin
    if (alu_signal == 6'd25) {hi_m, lo_m} <= 64'(alu_dataA) * 64'(alu_dataB);
  end

  always_comb begin
    case (alu_signal)
      6'd36:   alu_output = alu_dataA & alu_dataB;
      6'd37:   alu_output = alu_dataA | alu_dataB;
      6'd32:   alu_output = alu_dataA + alu_dataB;
      6'd34:   alu_output = alu_dataA - alu_dataB;
      6'd42:   alu_output = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
      6'd2:    alu_output = alu_dataA >> alu_dataB[4:0];
      6'd16:   alu_output = hi_m;
      6'd18:   alu_output = lo_m;
      default: alu_output = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 6'd0;
    req_a = 32'd0;
    req_b = 32'd0;
  endtask

  // Returns the number of accept-relative edges until rsp_valid is sampled high.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      sig_log[k] = alu_signal;
      binv_log[k] = alu_binvert;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 32'(lat), 32'd1);
  endtask

  task automatic take_beat(input int stall, output logic [31:0] d, output logic hi,
                           output logic last, output logic err);
    d = rsp_data;
    hi = rsp_hi;
    last = rsp_last;
    err = rsp_err;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, d);
      check("stall_last", 32'(rsp_last), 32'(last));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic single(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int stall);
    int lat;
    logic [31:0] d;
    logic hi, last, err;
    issue(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    take_beat(stall, d, hi, last, err);
    check({tag, "_data"}, d, exp);
    check({tag, "_last"}, 32'(last), 32'd1);
    check({tag, "_hi"}, 32'(hi), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int n25;
    int vcnt;
    logic [31:0] d;
    logic hi, last, err;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_signal", 32'(alu_signal), 32'd0);
    check("rst_alu_dataA", alu_dataA, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_binvert", 32'(alu_binvert), 32'd0);
    reset = 1'b1;

    single("add", 6'd32, 32'd7, 32'd5, 32'd12, 0);
    single("and", 6'd36, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0);

    issue(6'd34, 32'd3, 32'd5);
    wait_valid(lat);
    check("sub_issue_sig", 32'(sig_log[1]), 32'd34);
    check("sub_binvert", 32'(binv_log[1]), 32'd1);
    take_beat(0, d, hi, last, err);
    check("sub_data", d, 32'hFFFFFFFE);

    single("slt", 6'd42, 32'hFFFFFFFF, 32'd1, 32'd1, 0);

    issue(6'd25, 32'hFFFFFFFF, 32'd2);
    wait_valid(lat);
    check("mul_lat", 32'(lat), 32'd36);
    n25 = 0;
    for (int k = 1; k < lat; k++) if (sig_log[k] == 6'd25) n25++;
    check("mul_n25", 32'(n25), 32'd33);
    check("mul_mfhi_sig", 32'(sig_log[34]), 32'd16);
    check("mul_mflo_sig", 32'(sig_log[35]), 32'd18);
    take_beat(0, d, hi, last, err);
    check("mul_hi_data", d, 32'd1);
    check("mul_hi_flag", 32'(hi), 32'd1);
    check("mul_hi_last", 32'(last), 32'd0);
    check("mul_lo_valid", 32'(rsp_valid), 32'd1);
    take_beat(0, d, hi, last, err);
    check("mul_lo_data", d, 32'hFFFFFFFE);
    check("mul_lo_flag", 32'(hi), 32'd0);
    check("mul_lo_last", 32'(last), 32'd1);
    check("mul_done_ready", 32'(req_ready), 32'd1);

    issue(6'd27, 32'd9, 32'd9);
    wait_valid(lat);
    check("bad_lat", 32'(lat), 32'd1);
    check("bad_alu_sig", 32'(sig_log[1]), 32'd0);
    take_beat(0, d, hi, last, err);
    check("bad_err", 32'(err), 32'd1);
    check("bad_data", d, 32'd0);
    check("bad_last", 32'(last), 32'd1);

    single("or_stall", 6'd37, 32'd12, 32'd3, 32'd15, 5);

    issue(6'd25, 32'd3, 32'd4);
    repeat (10) @(negedge clk);
    check("abort_in_mul", 32'(alu_signal), 32'd25);
    reset = 1'b0;
    #1;
    check("abort_alu_sig", 32'(alu_signal), 32'd0);
    check("abort_dataA", alu_dataA, 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    rsp_ready = 1'b0;
    check("abort_no_beat", 32'(vcnt), 32'd0);
    check("abort_idle_ready", 32'(req_ready), 32'd1);
    single("add_after", 6'd32, 32'd1, 32'd1, 32'd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
